// File: rtl/fetch_unit.sv
// Program counter, return-address stack and run/halt/fault control for the
// 9-bit CPU's instruction fetch; pc indexes a combinational instruction ROM.
module fetch_unit #(
  parameter int DEPTH      = 4,
  parameter int SUB_BASE   = 100,
  parameter int SUB_STRIDE = 32,
  localparam int DW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          br_take,
  input  logic [9:0]    br_target,
  input  logic          call_en,
  input  logic [3:0]    call_idx,
  input  logic          ret_en,
  input  logic          halt_en,
  output logic [9:0]    pc,
  output logic          running,
  output logic          done,
  output logic          fault,
  output logic [DW-1:0] depth
);

  localparam int          SLOTS = 1 << DW;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t     state;
  logic [9:0] stack [0:SLOTS-1];
  logic       advance;
  logic       push;

  // Entry address of subroutine idx, wrapped to the 10-bit address space.
  function automatic logic [9:0] sub_addr(input logic [3:0] idx);
    logic [31:0] a;
    a = 32'(SUB_BASE) + 32'(idx) * 32'(SUB_STRIDE);
    return a[9:0];
  endfunction

  assign advance = (state == RUN) && !stall;
  assign push    = advance && !halt_en && !ret_en && call_en && (depth != FULL);

  // Stack storage carries no reset; occupancy is tracked by depth alone.
  always_ff @(posedge clk) begin
    if (!reset && push)
      stack[depth] <= pc + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= 10'd0;
      depth   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        state   <= RUN;
        pc      <= 10'd0;
        depth   <= '0;
        running <= 1'b1;
        done    <= 1'b0;
        fault   <= 1'b0;
      end
    end else if (advance) begin
      if (halt_en) begin
        state   <= HALT;
        running <= 1'b0;
        done    <= 1'b1;
      end else if (ret_en) begin
        if (depth == '0) begin
          state   <= FAULT;
          running <= 1'b0;
          done    <= 1'b1;
          fault   <= 1'b1;
        end else begin
          pc    <= stack[depth - ONE];
          depth <= depth - ONE;
        end
      end else if (call_en) begin
        if (depth == FULL) begin
          state   <= FAULT;
          running <= 1'b0;
          done    <= 1'b1;
          fault   <= 1'b1;
        end else begin
          pc    <= sub_addr(call_idx);
          depth <= depth + ONE;
        end
      end else if (br_take) begin
        pc <= br_target;
      end else begin
        pc <= pc + 10'd1;
      end
    end
  end

endmodule
